// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register-file write port, arbitrating pipeline writeback against a multi-cycle unit.
// Tracks busy registers for outstanding multi-cycle results; define RFARB_PERF_EN to build the perf counters.
module rf_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_stall,
    input  logic            mc_issue,
    input  logic [AW-1:0]   mc_issue_rd,
    input  logic            mc_valid,
    input  logic [AW-1:0]   mc_rd,
    input  logic [XLEN-1:0] mc_data,
    output logic            mc_ready,
    input  logic            dec_valid,
    input  logic [AW-1:0]   dec_rs1,
    input  logic [AW-1:0]   dec_rs2,
    input  logic [AW-1:0]   dec_rd,
    output logic            hazard_stall,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_vec,
    output logic [31:0]     perf_conflicts,
    output logic [31:0]     perf_forced
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]   starve_q, starve_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            mc_commit_q, mc_commit_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            conflict, forced, grant_wb, grant_mc;

    always_comb begin
        conflict     = wb_valid && mc_valid;
        forced       = conflict && (starve_q == SW'(STARVE_LIMIT));
        grant_mc     = mc_valid && (!wb_valid || forced);
        grant_wb     = wb_valid && !forced;
        starve_d     = (conflict && !forced) ? starve_q + 1'b1 : '0;
        rf_we_d      = (grant_mc && mc_rd != '0) || (grant_wb && wb_rd != '0);
        rf_waddr_d   = grant_mc ? mc_rd : grant_wb ? wb_rd : rf_waddr_q;
        rf_wdata_d   = grant_mc ? mc_data : grant_wb ? wb_data : rf_wdata_q;
        mc_commit_d  = grant_mc && mc_rd != '0;
        // clear lands on the commit edge; a same-edge issue re-sets the bit
        busy_d       = busy_q & ~(NREG'(mc_commit_q) << rf_waddr_q);
        if (mc_issue && mc_issue_rd != '0) busy_d[mc_issue_rd] = 1'b1;
        hazard_stall = dec_valid && ((dec_rs1 != '0 && busy_q[dec_rs1]) ||
                                     (dec_rs2 != '0 && busy_q[dec_rs2]) ||
                                     (dec_rd  != '0 && busy_q[dec_rd]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mc_commit_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            starve_q    <= starve_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mc_commit_q <= mc_commit_d;
            busy_q      <= busy_d;
        end
    end

    assign wb_stall = forced;
    assign mc_ready = grant_mc;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy_vec = busy_q;

`ifdef RFARB_PERF_EN
    logic [31:0] conf_q, conf_d, forced_q, forced_d;

    always_comb begin
        conf_d   = conf_q + 32'(conflict);
        forced_d = forced_q + 32'(forced);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conf_q   <= '0;
            forced_q <= '0;
        end else begin
            conf_q   <= conf_d;
            forced_q <= forced_d;
        end
    end

    assign perf_conflicts = conf_q;
    assign perf_forced    = forced_q;
`else
    assign perf_conflicts = '0;
    assign perf_forced    = '0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scenario tasks with a queue of expected register-file writes.
module tb_rf_write_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wb_valid, mc_issue, mc_valid, dec_valid;
    logic [4:0]  wb_rd, mc_issue_rd, mc_rd, dec_rs1, dec_rs2, dec_rd;
    logic [31:0] wb_data, mc_data;
    logic        wb_stall, mc_ready, hazard_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, busy_vec, perf_conflicts, perf_forced;

    typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
    wr_t sb[$];
    wr_t e;
    int  n_cmp = 0, n_err = 0;

`ifdef RFARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    rf_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard_stall(hazard_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec),
        .perf_conflicts(perf_conflicts), .perf_forced(perf_forced)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mc_issue = 0; mc_issue_rd = 0; mc_valid = 0; mc_rd = 0; mc_data = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    function automatic wr_t pop_exp();
        wr_t x;
        x = 'x;
        if (sb.size() != 0) x = sb.pop_front();
        return x;
    endfunction

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick(); tick(); smp();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata, busy_vec, perf_conflicts, perf_forced} !== '0) begin
            n_err++;
            $display("FAIL reset_state: we=%b a=%0d d=%h busy=%h pc=%0d pf=%0d, want all 0",
                     rf_we, rf_waddr, rf_wdata, busy_vec, perf_conflicts, perf_forced);
        end
        tick();
        rst_n = 1;
    endtask

    task automatic test_wb_only();
        tick(); idle();
        wb_valid = 1; wb_rd = 5; wb_data = 32'hA5;
        sb.push_back('{5'd5, 32'hA5});
        smp();
        n_cmp++;
        if ({wb_stall, mc_ready, rf_we} !== 3'b000) begin
            n_err++;
            $display("FAIL wb_only_grant: stall=%b ready=%b we=%b, want 0 0 0", wb_stall, mc_ready, rf_we);
        end
        tick(); idle(); smp();
        e = pop_exp();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata, wb_stall} !== {1'b1, e.a, e.d, 1'b0}) begin
            n_err++;
            $display("FAIL wb_only_write: we=%b a=%0d d=%h stall=%b, want 1 %0d %h 0",
                     rf_we, rf_waddr, rf_wdata, wb_stall, e.a, e.d);
        end
        tick(); smp();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL wb_only_idle: we=%b, want 0", rf_we);
        end
    endtask

    task automatic run_conflict(input string nm, input int first);
        for (int i = 0; i < 5; i++) begin
            tick(); idle();
            rst_n = 1;
            wb_valid = 1; wb_rd = 5'(10 + i); wb_data = 32'(i);
            mc_valid = 1; mc_rd = 7; mc_data = 32'h77;
            sb.push_back(i < 4 ? '{5'(10 + i), 32'(i)} : '{5'd7, 32'h77});
            smp();
            n_cmp++;
            if ({mc_ready, wb_stall} !== (i == 4 ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL %s_grant%0d: ready=%b stall=%b, want %b", nm, i, mc_ready, wb_stall,
                         (i == 4 ? 2'b11 : 2'b00));
            end
            if (i == 0 && first == 0) begin
                n_cmp++;
                if ({busy_vec, rf_we} !== 33'd0) begin
                    n_err++;
                    $display("FAIL %s_after_reset: busy=%h we=%b, want 0 0", nm, busy_vec, rf_we);
                end
            end
            if (i > 0) begin
                e = pop_exp();
                n_cmp++;
                if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, e.a, e.d}) begin
                    n_err++;
                    $display("FAIL %s_write%0d: we=%b a=%0d d=%h, want 1 %0d %h", nm, i - 1,
                             rf_we, rf_waddr, rf_wdata, e.a, e.d);
                end
            end
        end
        tick(); idle(); smp();
        e = pop_exp();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, e.a, e.d}) begin
            n_err++;
            $display("FAIL %s_forced_write: we=%b a=%0d d=%h, want 1 %0d %h", nm,
                     rf_we, rf_waddr, rf_wdata, e.a, e.d);
        end
        n_cmp++;
        if ({perf_conflicts, perf_forced} !== {(PERF ? 32'd5 : 32'd0), (PERF ? 32'd1 : 32'd0)}) begin
            n_err++;
            $display("FAIL %s_perf: conflicts=%0d forced=%0d, want %0d %0d", nm, perf_conflicts,
                     perf_forced, PERF ? 5 : 0, PERF ? 1 : 0);
        end
    endtask

    task automatic test_starve();
        run_conflict("starve", 1);
    endtask

    task automatic test_hazard();
        tick(); idle();
        mc_issue = 1; mc_issue_rd = 9;
        smp();
        n_cmp++;
        if ({busy_vec, hazard_stall} !== 33'd0) begin
            n_err++;
            $display("FAIL hazard_issue: busy=%h hz=%b, want 0 0", busy_vec, hazard_stall);
        end
        for (int i = 1; i < 4; i++) begin
            tick(); idle();
            dec_valid = (i != 3);
            dec_rs1 = (i == 2) ? 5'd9 : 5'd1;
            dec_rs2 = (i == 2) ? 5'd0 : 5'd9;
            dec_rd = 2;
            smp();
            n_cmp++;
            if ({hazard_stall, busy_vec} !== {(i != 3), 32'h200}) begin
                n_err++;
                $display("FAIL hazard_wait%0d: hz=%b busy=%h, want %b 00000200", i, hazard_stall,
                         busy_vec, (i != 3));
            end
        end
        tick(); idle();
        dec_valid = 1; dec_rs2 = 9;
        mc_valid = 1; mc_rd = 9; mc_data = 32'h99;
        sb.push_back('{5'd9, 32'h99});
        smp();
        n_cmp++;
        if ({hazard_stall, mc_ready, busy_vec} !== {2'b11, 32'h200}) begin
            n_err++;
            $display("FAIL hazard_grant: hz=%b ready=%b busy=%h, want 1 1 00000200", hazard_stall,
                     mc_ready, busy_vec);
        end
        tick(); mc_valid = 0; smp();
        e = pop_exp();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata, hazard_stall, busy_vec} !== {1'b1, e.a, e.d, 1'b1, 32'h200}) begin
            n_err++;
            $display("FAIL hazard_commit: we=%b a=%0d d=%h hz=%b busy=%h, want 1 %0d %h 1 00000200",
                     rf_we, rf_waddr, rf_wdata, hazard_stall, busy_vec, e.a, e.d);
        end
        tick(); smp();
        n_cmp++;
        if ({hazard_stall, busy_vec} !== 33'd0) begin
            n_err++;
            $display("FAIL hazard_clear: hz=%b busy=%h, want 0 0", hazard_stall, busy_vec);
        end
    endtask

    task automatic test_x0();
        tick(); idle();
        mc_issue = 1; mc_issue_rd = 0;
        smp();
        tick(); idle();
        mc_valid = 1; mc_rd = 0; mc_data = 32'h55;
        smp();
        n_cmp++;
        if ({busy_vec, mc_ready} !== {32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL x0_issue: busy=%h ready=%b, want 0 1", busy_vec, mc_ready);
        end
        tick(); idle();
        wb_valid = 1; wb_rd = 0; wb_data = 1;
        smp();
        n_cmp++;
        if ({rf_we, wb_stall} !== 2'b00) begin
            n_err++;
            $display("FAIL x0_mc_write: we=%b stall=%b, want 0 0", rf_we, wb_stall);
        end
        tick(); idle(); smp();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL x0_wb_write: we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_same_edge();
        tick(); idle(); mc_issue = 1; mc_issue_rd = 3; smp();
        tick(); idle();
        mc_valid = 1; mc_rd = 3; mc_data = 32'h33;
        sb.push_back('{5'd3, 32'h33});
        smp();
        n_cmp++;
        if ({busy_vec, mc_ready} !== {32'h8, 1'b1}) begin
            n_err++;
            $display("FAIL same_grant: busy=%h ready=%b, want 00000008 1", busy_vec, mc_ready);
        end
        tick(); idle(); mc_issue = 1; mc_issue_rd = 3; smp();
        e = pop_exp();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, e.a, e.d}) begin
            n_err++;
            $display("FAIL same_write: we=%b a=%0d d=%h, want 1 %0d %h", rf_we, rf_waddr, rf_wdata, e.a, e.d);
        end
        tick(); idle(); smp();
        n_cmp++;
        if (busy_vec !== 32'h8) begin
            n_err++;
            $display("FAIL same_set_wins: busy=%h, want 00000008", busy_vec);
        end
        tick(); idle();
        mc_valid = 1; mc_rd = 3; mc_data = 32'h34;
        sb.push_back('{5'd3, 32'h34});
        smp();
        tick(); idle(); smp();
        e = pop_exp();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, e.a, e.d}) begin
            n_err++;
            $display("FAIL same_write2: we=%b a=%0d d=%h, want 1 %0d %h", rf_we, rf_waddr, rf_wdata, e.a, e.d);
        end
        tick(); smp();
        n_cmp++;
        if (busy_vec !== 32'h0) begin
            n_err++;
            $display("FAIL same_clear: busy=%h, want 0", busy_vec);
        end
    endtask

    task automatic test_reset_mid();
        tick(); idle(); mc_issue = 1; mc_issue_rd = 9; smp();
        tick(); idle(); mc_issue = 1; mc_issue_rd = 10; smp();
        for (int i = 0; i < 2; i++) begin
            tick(); idle();
            wb_valid = 1; wb_rd = 5'(1 + i); wb_data = 32'h100 + 32'(i);
            mc_valid = 1; mc_rd = 20; mc_data = 32'h2020;
            sb.push_back('{5'(1 + i), 32'h100 + 32'(i)});
            smp();
            n_cmp++;
            if ({mc_ready, busy_vec} !== {1'b0, 32'h600}) begin
                n_err++;
                $display("FAIL rmid_pre%0d: ready=%b busy=%h, want 0 00000600", i, mc_ready, busy_vec);
            end
            if (i == 1) begin
                e = pop_exp();
                n_cmp++;
                if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, e.a, e.d}) begin
                    n_err++;
                    $display("FAIL rmid_write0: we=%b a=%0d d=%h, want 1 %0d %h", rf_we, rf_waddr,
                             rf_wdata, e.a, e.d);
                end
            end
        end
        tick(); idle(); rst_n = 0; smp();
        e = pop_exp();
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, e.a, e.d}) begin
            n_err++;
            $display("FAIL rmid_write1: we=%b a=%0d d=%h, want 1 %0d %h", rf_we, rf_waddr, rf_wdata, e.a, e.d);
        end
        run_conflict("rmid", 0);
    endtask

    initial begin
        idle();
        test_reset();
        test_wb_only();
        test_starve();
        test_hazard();
        test_x0();
        test_same_edge();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
